// File: rtl/defines_pkg.sv
// rtl/defines_pkg.sv - shared types and constants for the GNN node scheduler
package defines_pkg;

    localparam int NUM_GNN_NODES = 4;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_L1_MUL01,
        PH_L1_MUL23,
        PH_L1_ADD,
        PH_L1_WB,
        PH_L2_MUL,
        PH_L2_WB,
        PH_DONE
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_MUL01,
        ST_L1_MUL23,
        ST_L1_ADD,
        ST_L1_WB,
        ST_L2_MUL,
        ST_L2_WB,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/next_node_find.sv
// rtl/next_node_find.sv - next enabled node above an index, or lowest enabled node
module next_node_find #(
    parameter int NUM_NODES = 4,
    parameter int NODE_W    = $clog2(NUM_NODES)
) (
    input  logic [NUM_NODES-1:0] mask_i,
    input  logic [NODE_W-1:0]    cur_i,
    input  logic                 from_start_i,
    output logic [NODE_W-1:0]    next_o,
    output logic                 none_o
);

    // from_start_i treats the current index as -1, giving the lowest set bit.
    always_comb begin
        next_o = '0;
        none_o = 1'b1;
        for (int i = NUM_NODES - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (i > int'(cur_i)))) begin
                next_o = NODE_W'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/gnn_node_scheduler.sv
// rtl/gnn_node_scheduler.sv - time-multiplexes one two-layer engine across graph nodes
module gnn_node_scheduler
    import defines_pkg::*;
#(
    parameter int NUM_NODES = NUM_GNN_NODES,
    parameter int NODE_W    = $clog2(NUM_NODES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_ready,
    input  logic [NUM_NODES-1:0] node_mask,
    input  logic                 abort,
    output logic                 busy,
    output phase_t               phase,
    output logic [NODE_W-1:0]    node_sel,
    output logic                 eng_clk_en,
    output logic [NUM_NODES-1:0] l1_wr_en,
    output logic [NUM_NODES-1:0] out_wr_en,
    output logic [NUM_NODES-1:0] out_ready,
    output logic                 done
);

    sched_state_t         state_q, state_d;
    logic [NODE_W-1:0]    node_sel_q, node_sel_d;
    logic [NUM_NODES-1:0] mask_q, mask_d;
    logic [NUM_NODES-1:0] out_ready_q, out_ready_d;
    logic                 in_ready_prev_q;

    logic                 start;
    logic [NODE_W-1:0]    walk_next, low_next;
    logic                 walk_none, low_none;
    logic [NUM_NODES-1:0] low_mask;

    assign start = in_ready & ~in_ready_prev_q;

    // In IDLE the lowest-bit lookup sees the live mask so the first node is known at start.
    assign low_mask = (state_q == ST_IDLE) ? node_mask : mask_q;

    next_node_find #(.NUM_NODES(NUM_NODES), .NODE_W(NODE_W)) u_walk (
        .mask_i       (mask_q),
        .cur_i        (node_sel_q),
        .from_start_i (1'b0),
        .next_o       (walk_next),
        .none_o       (walk_none)
    );

    next_node_find #(.NUM_NODES(NUM_NODES), .NODE_W(NODE_W)) u_lowest (
        .mask_i       (low_mask),
        .cur_i        ('0),
        .from_start_i (1'b1),
        .next_o       (low_next),
        .none_o       (low_none)
    );

    always_comb begin
        state_d     = state_q;
        node_sel_d  = node_sel_q;
        mask_d      = mask_q;
        out_ready_d = out_ready_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !low_none) begin
                    state_d     = ST_L1_MUL01;
                    node_sel_d  = low_next;
                    mask_d      = node_mask;
                    out_ready_d = '0;
                end
            end
            ST_L1_MUL01: state_d = ST_L1_MUL23;
            ST_L1_MUL23: state_d = ST_L1_ADD;
            ST_L1_ADD:   state_d = ST_L1_WB;
            ST_L1_WB: begin
                if (!walk_none) begin
                    state_d    = ST_L1_MUL01;
                    node_sel_d = walk_next;
                end else begin
                    state_d    = ST_L2_MUL;
                    node_sel_d = low_next;
                end
            end
            ST_L2_MUL:   state_d = ST_L2_WB;
            ST_L2_WB: begin
                out_ready_d[node_sel_q] = 1'b1;
                if (!walk_none) begin
                    state_d    = ST_L2_MUL;
                    node_sel_d = walk_next;
                end else begin
                    state_d    = ST_DONE;
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // Abort overrides every transition, including a pending result write.
        if (abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            out_ready_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            node_sel_q      <= '0;
            mask_q          <= '0;
            out_ready_q     <= '0;
            in_ready_prev_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            node_sel_q      <= node_sel_d;
            mask_q          <= mask_d;
            out_ready_q     <= out_ready_d;
            in_ready_prev_q <= in_ready;
        end
    end

    always_comb begin
        phase = PH_IDLE;
        unique case (state_q)
            ST_IDLE:     phase = PH_IDLE;
            ST_L1_MUL01: phase = PH_L1_MUL01;
            ST_L1_MUL23: phase = PH_L1_MUL23;
            ST_L1_ADD:   phase = PH_L1_ADD;
            ST_L1_WB:    phase = PH_L1_WB;
            ST_L2_MUL:   phase = PH_L2_MUL;
            ST_L2_WB:    phase = PH_L2_WB;
            ST_DONE:     phase = PH_DONE;
            default:     phase = PH_IDLE;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign eng_clk_en = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign node_sel   = node_sel_q;
    assign out_ready  = out_ready_q;
    assign l1_wr_en   = (state_q == ST_L1_WB) ? (NUM_NODES'(1) << node_sel_q) : '0;
    assign out_wr_en  = (state_q == ST_L2_WB) ? (NUM_NODES'(1) << node_sel_q) : '0;

endmodule

// File: tb/tb_gnn_node_scheduler.sv
// tb/tb_gnn_node_scheduler.sv - directed scoreboard bench for gnn_node_scheduler
module tb_gnn_node_scheduler;
    import defines_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_ready;
    logic [3:0] node_mask;
    logic       abort;
    logic       busy;
    phase_t     phase;
    logic [1:0] node_sel;
    logic       eng_clk_en;
    logic [3:0] l1_wr_en;
    logic [3:0] out_wr_en;
    logic [3:0] out_ready;
    logic       done;

    typedef struct packed {
        int       cyc;
        logic [3:0] l1;
        logic [3:0] ow;
        logic       dn;
    } ev_t;

    ev_t sb[$];
    int  cyc;
    int  n_cmp;
    int  n_bad;

    gnn_node_scheduler #(.NUM_NODES(4), .NODE_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_ready   (in_ready),
        .node_mask  (node_mask),
        .abort      (abort),
        .busy       (busy),
        .phase      (phase),
        .node_sel   (node_sel),
        .eng_clk_en (eng_clk_en),
        .l1_wr_en   (l1_wr_en),
        .out_wr_en  (out_wr_en),
        .out_ready  (out_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected strobe/done events for a run starting at edge k; events after 'limit' are dropped.
    task automatic push_run(input logic [3:0] m, input int k, input int limit);
        int  j;
        int  n;
        ev_t e;
        j = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.cyc = k + 4 * j + 3; e.l1 = 4'(1 << i); e.ow = 4'h0; e.dn = 1'b0;
                if (e.cyc <= limit) sb.push_back(e);
                j++;
            end
        end
        n = j;
        j = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e.cyc = k + 4 * n + 2 * j + 1; e.l1 = 4'h0; e.ow = 4'(1 << i); e.dn = 1'b0;
                if (e.cyc <= limit) sb.push_back(e);
                j++;
            end
        end
        e.cyc = k + 6 * n; e.l1 = 4'h0; e.ow = 4'h0; e.dn = 1'b1;
        if (e.cyc <= limit) sb.push_back(e);
    endtask

    // Advance one clock; sample at the falling edge and score any strobe or done.
    task automatic tick();
        ev_t obs;
        ev_t exp;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if ((l1_wr_en != 4'h0) || (out_wr_en != 4'h0) || done) begin
            obs.cyc = cyc; obs.l1 = l1_wr_en; obs.ow = out_wr_en; obs.dn = done;
            n_cmp++;
            assert (sb.size() > 0) else begin
                n_bad++;
                $error("FAIL unexpected_event: observed cyc=%0d l1=%b ow=%b dn=%b expected none",
                       obs.cyc, obs.l1, obs.ow, obs.dn);
            end
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                n_cmp++;
                assert (obs === exp) else begin
                    n_bad++;
                    $error("FAIL event: observed cyc=%0d l1=%b ow=%b dn=%b expected cyc=%0d l1=%b ow=%b dn=%b",
                           obs.cyc, obs.l1, obs.ow, obs.dn, exp.cyc, exp.l1, exp.ow, exp.dn);
                end
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  32'(busy), 32'd0);
        chk({tag, "_phase"}, 32'(phase), 32'(PH_IDLE));
        chk({tag, "_sel"},   32'(node_sel), 32'd0);
        chk({tag, "_clken"}, 32'(eng_clk_en), 32'd0);
        chk({tag, "_l1wr"},  32'(l1_wr_en), 32'd0);
        chk({tag, "_outwr"}, 32'(out_wr_en), 32'd0);
        chk({tag, "_ordy"},  32'(out_ready), 32'd0);
        chk({tag, "_done"},  32'(done), 32'd0);
    endtask

    initial begin
        int k;
        int exp_sel;
        cyc = 0;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        in_ready = 1'b0;
        node_mask = 4'h0;
        abort = 1'b0;

        tick();
        tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // Full mask; node_mask disturbed mid-run, in_ready held high across DONE.
        node_mask = 4'hF;
        in_ready = 1'b1;
        k = cyc + 1;
        push_run(4'hF, k, 1000000);
        for (int t = 0; t < 24; t++) begin
            tick();
            exp_sel = (t < 16) ? (t / 4) : ((t - 16) / 2);
            chk("full_sel", 32'(node_sel), 32'(exp_sel));
            if (t == 4) node_mask = 4'h1;
            if (t == 0) chk("full_clken", 32'(eng_clk_en), 32'd1);
        end
        tick();
        chk("full_done_phase", 32'(phase), 32'(PH_DONE));
        chk("full_done_busy", 32'(busy), 32'd1);
        tick();
        chk("full_busy_after", 32'(busy), 32'd0);
        chk("full_ordy", 32'(out_ready), 32'hF);
        chk("full_clken_idle", 32'(eng_clk_en), 32'd0);
        repeat (3) tick();
        chk("held_no_restart", 32'(busy), 32'd0);
        chk("full_sb_empty", 32'(sb.size()), 32'd0);

        // Second rise with sparse mask; out_ready cleared at the new start.
        in_ready = 1'b0;
        node_mask = 4'hA;
        tick();
        in_ready = 1'b1;
        k = cyc + 1;
        push_run(4'hA, k, 1000000);
        tick();
        chk("sparse_ordy_clr", 32'(out_ready), 32'd0);
        chk("sparse_first_sel", 32'(node_sel), 32'd1);
        repeat (11) tick();
        tick();
        chk("sparse_done_phase", 32'(phase), 32'(PH_DONE));
        tick();
        chk("sparse_ordy", 32'(out_ready), 32'hA);
        chk("sparse_busy", 32'(busy), 32'd0);
        chk("sparse_sb_empty", 32'(sb.size()), 32'd0);

        // Empty mask: start ignored.
        in_ready = 1'b0;
        tick();
        node_mask = 4'h0;
        in_ready = 1'b1;
        repeat (4) tick();
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_ordy_kept", 32'(out_ready), 32'hA);

        // Abort during L2_MUL of node 2.
        in_ready = 1'b0;
        node_mask = 4'hF;
        tick();
        in_ready = 1'b1;
        k = cyc + 1;
        push_run(4'hF, k, k + 20);
        repeat (21) tick();
        chk("abort_at_phase", 32'(phase), 32'(PH_L2_MUL));
        chk("abort_at_sel", 32'(node_sel), 32'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ordy", 32'(out_ready), 32'd0);
        chk("abort_phase", 32'(phase), 32'(PH_IDLE));
        repeat (4) tick();
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle_busy", 32'(busy), 32'd0);

        // Full run after abort.
        in_ready = 1'b0;
        tick();
        in_ready = 1'b1;
        k = cyc + 1;
        push_run(4'hF, k, 1000000);
        repeat (25) tick();
        tick();
        chk("rerun_ordy", 32'(out_ready), 32'hF);
        chk("rerun_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-run.
        in_ready = 1'b0;
        tick();
        in_ready = 1'b1;
        k = cyc + 1;
        push_run(4'hF, k, k + 9);
        repeat (10) tick();
        chk("prerst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst");
        tick();
        rst_n = 1'b1;
        in_ready = 1'b0;
        tick();
        chk("postrst_busy", 32'(busy), 32'd0);
        chk("postrst_sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
